sram_ab_arb: RTL and testbench

- Shares one word-addressed two-port SRAM among N_RD read clients and N_WR write clients.
  - Port A of the SRAM is read-only with fixed read latency.
  - Port B is write-only with per-byte masks.
- Round-robin arbitration on each port.
- Returned read data is steered to the issuing client with a tag pipeline matched to SRAM latency.
- Sits between EPU compute/DMA clients and the SRAM instance.

---
 rtl/sram_arb_pkg.sv | 20 ++
 rtl/sram_ab_arb_rr.sv | 46 ++++
 rtl/sram_ab_arb.sv | 149 ++++++++++++++
 tb/tb_sram_ab_arb.sv | 234 +++++++++++++++++++++++
 4 files changed

// File: rtl/sram_arb_pkg.sv
// Shared types and helpers for the two-port SRAM arbiter.
package sram_arb_pkg;

  // Width of the per-client grant counters (stats build only).
  localparam int CNT_W     = 16;
  // The tag index is sized for the largest supported client count (8).
  localparam int TAG_IDX_W = 3;

  // Index width for n clients; never narrower than one bit.
  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  // One tag pipeline stage: read in flight and which client issued it.
  typedef struct packed {
    logic                 valid;
    logic [TAG_IDX_W-1:0] idx;
  } rd_tag_t;

endpackage

// File: rtl/sram_ab_arb_rr.sv
// Round-robin arbiter: combinational grant from req and the pointer register.
// The pointer moves one past the winner; it holds when nothing is granted.
module rr_arb
  import sram_arb_pkg::*;
#(
  parameter int N  = 4,
  parameter int IW = idx_w(N)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [N-1:0]  req,
  output logic [N-1:0]  gnt,
  output logic [IW-1:0] idx
);

  logic [IW-1:0] ptr;
  logic          found;
  int            j;

  // First asserted request at or after ptr, wrapping; nothing while in reset.
  always_comb begin
    gnt   = '0;
    idx   = '0;
    found = 1'b0;
    j     = 0;
    for (int k = 0; k < N; k++) begin
      j = (int'(ptr) + k) % N;
      if (!found && req[j]) begin
        found  = 1'b1;
        gnt[j] = 1'b1;
        idx    = IW'(j);
      end
    end
    if (!rst_n) begin
      gnt = '0;
      idx = '0;
    end
  end

  // Pointer advances past the granted client.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)      ptr <= '0;
    else if (|gnt)   ptr <= (idx == IW'(N - 1)) ? '0 : idx + IW'(1);
  end

endmodule

// File: rtl/sram_ab_arb.sv
// Arbitrates N_RD read clients onto SRAM port A and N_WR write clients onto
// port B, and steers port-A read data back via a tag pipeline of RD_LAT stages.
// Optional per-client grant counters: define SRAM_ARB_STATS_EN.
module sram_ab_arb
  import sram_arb_pkg::*;
#(
  parameter int N_RD   = 4,
  parameter int N_WR   = 2,
  parameter int ADDR_W = 10,
  parameter int DATA_W = 32,
  parameter int BYTE_W = DATA_W / 8,
  parameter int RD_LAT = 2
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [N_RD-1:0]          rd_req,
  input  logic [N_RD*ADDR_W-1:0]   rd_addr,
  output logic [N_RD-1:0]          rd_gnt,
  output logic [N_RD-1:0]          rsp_valid,
  output logic [DATA_W-1:0]        rsp_data,
  input  logic [N_WR-1:0]          wr_req,
  input  logic [N_WR*ADDR_W-1:0]   wr_addr,
  input  logic [N_WR*DATA_W-1:0]   wr_data,
  input  logic [N_WR*BYTE_W-1:0]   wr_mask,
  output logic [N_WR-1:0]          wr_gnt,
  output logic                     a_en,
  output logic                     a_re,
  output logic [ADDR_W-1:0]        a_addr,
  input  logic [DATA_W-1:0]        a_rdata,
  input  logic                     a_rvalid,
  output logic                     b_en,
  output logic                     b_we,
  output logic [ADDR_W-1:0]        b_addr,
  output logic [DATA_W-1:0]        b_wdata,
  output logic [BYTE_W-1:0]        b_wmask,
`ifdef SRAM_ARB_STATS_EN
  input  logic                     stats_clr,
  output logic [N_RD*CNT_W-1:0]    rd_gnt_cnt,
  output logic [N_WR*CNT_W-1:0]    wr_gnt_cnt,
`endif
  output logic                     rsp_err
);

  localparam int RIW = idx_w(N_RD);
  localparam int WIW = idx_w(N_WR);

  logic [RIW-1:0]    rd_idx;
  logic [WIW-1:0]    wr_idx;
  rd_tag_t [RD_LAT-1:0] tag_pipe;
  rd_tag_t           tag_last;
  logic [RD_LAT-1:0] blank_sr;
  logic              blank;
  logic              rsp_fire;
  logic [N_RD-1:0]   rsp_hot;

  rr_arb #(.N(N_RD)) u_rd_arb (
    .clk   (clk),
    .rst_n (rst_n),
    .req   (rd_req),
    .gnt   (rd_gnt),
    .idx   (rd_idx)
  );

  rr_arb #(.N(N_WR)) u_wr_arb (
    .clk   (clk),
    .rst_n (rst_n),
    .req   (wr_req),
    .gnt   (wr_gnt),
    .idx   (wr_idx)
  );

  // SRAM commands follow the grants in the same cycle; idle buses read zero.
  always_comb begin
    a_en    = |rd_gnt;
    a_re    = |rd_gnt;
    a_addr  = a_en ? rd_addr[rd_idx*ADDR_W +: ADDR_W] : '0;
    b_en    = |wr_gnt;
    b_we    = |wr_gnt;
    b_addr  = b_en ? wr_addr[wr_idx*ADDR_W +: ADDR_W] : '0;
    b_wdata = b_en ? wr_data[wr_idx*DATA_W +: DATA_W] : '0;
    b_wmask = b_en ? wr_mask[wr_idx*BYTE_W +: BYTE_W] : '0;
  end

  // Tag pipeline: the last stage lines up with a_rvalid for the same read.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tag_pipe <= '0;
    end else begin
      for (int k = RD_LAT - 1; k > 0; k--) tag_pipe[k] <= tag_pipe[k-1];
      tag_pipe[0] <= '{valid: |rd_gnt, idx: TAG_IDX_W'(rd_idx)};
    end
  end

  assign tag_last = tag_pipe[RD_LAT-1];

  // Blanking window: SRAM returns from reads issued before reset are dropped.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) blank_sr <= '1;
    else        blank_sr <= blank_sr >> 1;
  end

  assign blank    = blank_sr[0];
  assign rsp_fire = a_rvalid && tag_last.valid;

  // Decode the returning tag into a one-hot client strobe.
  always_comb begin
    rsp_hot = '0;
    for (int i = 0; i < N_RD; i++)
      rsp_hot[i] = rsp_fire && (tag_last.idx == TAG_IDX_W'(i));
  end

  // Registered response; data holds between responses. Error is sticky.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rsp_valid <= '0;
      rsp_data  <= '0;
      rsp_err   <= 1'b0;
    end else begin
      rsp_valid <= rsp_hot;
      if (rsp_fire) rsp_data <= a_rdata;
      if (!blank && (a_rvalid != tag_last.valid)) rsp_err <= 1'b1;
    end
  end

`ifdef SRAM_ARB_STATS_EN
  logic [N_RD-1:0][CNT_W-1:0] rd_cnt;
  logic [N_WR-1:0][CNT_W-1:0] wr_cnt;

  // Saturating grant counters; clear wins over increment.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_cnt <= '0;
      wr_cnt <= '0;
    end else if (stats_clr) begin
      rd_cnt <= '0;
      wr_cnt <= '0;
    end else begin
      for (int i = 0; i < N_RD; i++)
        if (rd_gnt[i] && (rd_cnt[i] != '1)) rd_cnt[i] <= rd_cnt[i] + 1'b1;
      for (int i = 0; i < N_WR; i++)
        if (wr_gnt[i] && (wr_cnt[i] != '1)) wr_cnt[i] <= wr_cnt[i] + 1'b1;
    end
  end

  assign rd_gnt_cnt = rd_cnt;
  assign wr_gnt_cnt = wr_cnt;
`endif

endmodule

// File: tb/tb_sram_ab_arb.sv
// Directed bench for sram_ab_arb with a write-first SRAM model (latency 2).
// Stimulus pushes expected responses; a negedge monitor pops and compares.
module tb_sram_ab_arb;

  localparam int N_RD = 4, N_WR = 2, AW = 10, DW = 32, BW = 4, LAT = 2;

  logic                 clk = 1'b0;
  logic                 rst_n = 1'b0;
  logic [N_RD-1:0]      rd_req = '0;
  logic [N_RD*AW-1:0]   rd_addr = '0;
  logic [N_RD-1:0]      rd_gnt, rsp_valid;
  logic [DW-1:0]        rsp_data;
  logic [N_WR-1:0]      wr_req = '0;
  logic [N_WR*AW-1:0]   wr_addr = '0;
  logic [N_WR*DW-1:0]   wr_data = '0;
  logic [N_WR*BW-1:0]   wr_mask = '0;
  logic [N_WR-1:0]      wr_gnt;
  logic                 a_en, a_re, b_en, b_we, a_rvalid, rsp_err;
  logic [AW-1:0]        a_addr, b_addr;
  logic [DW-1:0]        a_rdata, b_wdata;
  logic [BW-1:0]        b_wmask;
`ifdef SRAM_ARB_STATS_EN
  logic [N_RD*16-1:0]   rd_gnt_cnt;
  logic [N_WR*16-1:0]   wr_gnt_cnt;
`endif

  sram_ab_arb #(.N_RD(N_RD), .N_WR(N_WR), .ADDR_W(AW), .DATA_W(DW), .RD_LAT(LAT)) dut (
    .clk(clk), .rst_n(rst_n),
    .rd_req(rd_req), .rd_addr(rd_addr), .rd_gnt(rd_gnt),
    .rsp_valid(rsp_valid), .rsp_data(rsp_data),
    .wr_req(wr_req), .wr_addr(wr_addr), .wr_data(wr_data), .wr_mask(wr_mask), .wr_gnt(wr_gnt),
    .a_en(a_en), .a_re(a_re), .a_addr(a_addr), .a_rdata(a_rdata), .a_rvalid(a_rvalid),
    .b_en(b_en), .b_we(b_we), .b_addr(b_addr), .b_wdata(b_wdata), .b_wmask(b_wmask),
`ifdef SRAM_ARB_STATS_EN
    .stats_clr(1'b0), .rd_gnt_cnt(rd_gnt_cnt), .wr_gnt_cnt(wr_gnt_cnt),
`endif
    .rsp_err(rsp_err)
  );

  always #5 clk = ~clk;

  // Two-port SRAM model: masked write lands before a same-edge read (write-first).
  logic [DW-1:0] mem [1024];
  logic          rv0 = 1'b0, rv1 = 1'b0, inject = 1'b0;
  logic [DW-1:0] rd0 = '0, rd1 = '0;
  assign a_rvalid = rv1 | inject;
  assign a_rdata  = rd1;

  always @(posedge clk) begin
    rv1 <= rv0;
    rd1 <= rd0;
    if (b_en && b_we)
      for (int b = 0; b < BW; b++)
        if (b_wmask[b]) mem[b_addr][b*8 +: 8] = b_wdata[b*8 +: 8];
    rv0 <= a_en && a_re;
    rd0 <= (a_en && a_re) ? mem[a_addr] : '0;
  end

  int cyc = 0;
  always @(posedge clk) cyc++;

  typedef struct { int client; logic [DW-1:0] data; int due; } exp_t;
  exp_t q[$];
  int n_cmp = 0, n_err = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input int c, input logic [DW-1:0] d);
    q.push_back('{client: c, data: d, due: cyc + LAT + 1});
  endtask

  // Monitor: every response strobe must match the oldest expected entry.
  always @(negedge clk) begin
    if (rsp_valid != '0) begin
      if (q.size() == 0) begin
        chk("rsp_unexpected", 64'(rsp_valid), 64'd0);
      end else begin
        exp_t e;
        e = q.pop_front();
        chk("rsp_client", 64'(rsp_valid), 64'(1 << e.client));
        chk("rsp_data", 64'(rsp_data), 64'(e.data));
        chk("rsp_cycle", 64'(cyc), 64'(e.due));
      end
    end
  end

  initial begin
    for (int i = 0; i < 1024; i++) mem[i] = '0;
    for (int i = 0; i < 4; i++) mem[10'h10 + i] = 32'hA0A00010 + i;
    mem[10'h20] = 32'h11223344;

    // Reset state with requests held: everything forced quiet.
    rd_req = 4'hF; wr_req = 2'b11;
    @(negedge clk);
    chk("rst_rd_gnt", 64'(rd_gnt), 0);
    chk("rst_wr_gnt", 64'(wr_gnt), 0);
    chk("rst_a_en", 64'(a_en), 0);
    chk("rst_b_en", 64'(b_en), 0);
    chk("rst_rsp_valid", 64'(rsp_valid), 0);
    chk("rst_rsp_data", 64'(rsp_data), 0);
    chk("rst_rsp_err", 64'(rsp_err), 0);
    tick();
    rd_req = '0; wr_req = '0; rst_n = 1'b1;
    tick(); tick();

    // All four readers held: grants rotate 0,1,2,3,0.
    for (int i = 0; i < 4; i++) rd_addr[i*AW +: AW] = AW'(10'h10 + i);
    rd_req = 4'hF;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      chk("t1_rd_gnt", 64'(rd_gnt), 64'(1 << (k % 4)));
      chk("t1_a_addr", 64'(a_addr), 64'(10'h10 + (k % 4)));
      push(k % 4, 32'hA0A00010 + (k % 4));
      tick();
    end
    rd_req = '0;
    @(negedge clk);
    chk("idle_a_en", 64'(a_en), 0);
    chk("idle_a_addr", 64'(a_addr), 0);
    tick();

    // Masked write (bytes 0 and 2) from client 1, then read back.
    wr_req = 2'b10;
    wr_addr[AW +: AW] = 10'h20;
    wr_data[DW +: DW] = 32'hAABBCCDD;
    wr_mask[BW +: BW] = 4'b0101;
    @(negedge clk);
    chk("t2_wr_gnt", 64'(wr_gnt), 2'b10);
    chk("t2_b_addr", 64'(b_addr), 10'h20);
    chk("t2_b_wmask", 64'(b_wmask), 4'b0101);
    chk("t2_b_wdata", 64'(b_wdata), 32'hAABBCCDD);
    tick();
    wr_req = '0;
    rd_req = 4'b0001; rd_addr[0 +: AW] = 10'h20;
    @(negedge clk);
    chk("t2_rd_gnt", 64'(rd_gnt), 4'b0001);
    push(0, 32'h11BB33DD);   // old 11223344, bytes 2 and 0 replaced by BB, DD
    tick();
    rd_req = '0;

    // Same-cycle read and write to 0x30: read returns the new word.
    wr_req = 2'b01; wr_addr[0 +: AW] = 10'h30;
    wr_data[0 +: DW] = 32'hDEADBEEF; wr_mask[0 +: BW] = 4'hF;
    rd_req = 4'b0010; rd_addr[AW +: AW] = 10'h30;
    @(negedge clk);
    chk("t3_rd_gnt", 64'(rd_gnt), 4'b0010);
    chk("t3_wr_gnt", 64'(wr_gnt), 2'b01);
    chk("t3_b_en", 64'(b_en), 1);
    push(1, 32'hDEADBEEF);
    tick();
    rd_req = '0; wr_req = '0;

    // Single requester granted every cycle; then the pointer sits at 3.
    rd_req = 4'b0100; rd_addr[2*AW +: AW] = 10'h12;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      chk("t4_single_gnt", 64'(rd_gnt), 4'b0100);
      push(2, 32'hA0A00012);
      tick();
    end
    rd_req = 4'b1001; rd_addr[0 +: AW] = 10'h10; rd_addr[3*AW +: AW] = 10'h13;
    @(negedge clk);
    chk("t4_ptr3_gnt", 64'(rd_gnt), 4'b1000);
    push(3, 32'hA0A00013);
    tick();
    @(negedge clk);
    chk("t4_wrap_gnt", 64'(rd_gnt), 4'b0001);
    push(0, 32'hA0A00010);
    tick();
    rd_req = '0;
    repeat (4) tick();

    // Reset one cycle after a grant: the in-flight read vanishes silently.
    rd_req = 4'b0001; rd_addr[0 +: AW] = 10'h11;
    @(negedge clk);
    chk("t5_gnt", 64'(rd_gnt), 4'b0001);
    tick();
    rst_n = 1'b0;
    @(negedge clk);
    chk("t5_rst_gnt", 64'(rd_gnt), 0);
    tick();
    rst_n = 1'b1; rd_req = '0;
    repeat (4) tick();
    chk("t5_no_err", 64'(rsp_err), 0);
    rd_req = 4'b0001; rd_addr[0 +: AW] = 10'h13;
    @(negedge clk);
    chk("t5_post_gnt", 64'(rd_gnt), 4'b0001);
    push(0, 32'hA0A00013);
    tick();
    rd_req = '0;
    repeat (5) tick();

    // Stray a_rvalid: ignored in the last blanking cycle, sticky error after.
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;          // cycle 0 after release
    tick();
    inject = 1'b1;         // cycle 1: still blanked
    tick();
    inject = 1'b0;
    @(negedge clk);
    chk("t6_blank_drop", 64'(rsp_err), 0);
    repeat (3) tick();
    inject = 1'b1;         // cycle 5
    tick();
    inject = 1'b0;
    @(negedge clk);
    chk("t6_err_set", 64'(rsp_err), 1);
    repeat (3) tick();
    chk("t6_err_sticky", 64'(rsp_err), 1);
    rst_n = 1'b0;
    #1;
    chk("t6_err_clr", 64'(rsp_err), 0);
    tick();
    rst_n = 1'b1;
    repeat (3) tick();

    chk("sb_drained", 64'(q.size()), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
